// File: rtl/voice_allocator.sv
// voice_allocator: polyphonic note-to-voice allocator.
// Each accepted note event is scanned against every voice slot, one slot per
// cycle, then applied in a single commit cycle. Voices are ranked by age of
// their last note-on (rank 0 = most recent). A note-on for a note that is
// already sounding retriggers that voice; otherwise the lowest-index free voice
// is used.
// Optional feature macro: VOICE_STEAL_EN. When it is defined, a note-on that
// finds no free voice steals the oldest voice. When it is not defined, that
// note-on is dropped and reported on the dropped output.
module voice_allocator #(
  parameter int NUM_VOICES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ev_valid,
  output logic                    ev_ready,
  input  logic                    ev_on,
  input  logic [6:0]              ev_note,
  input  logic [6:0]              ev_velocity,
  input  logic                    panic,
  output logic [NUM_VOICES-1:0]   voice_active,
  output logic [7*NUM_VOICES-1:0] voice_note,
  output logic [7*NUM_VOICES-1:0] voice_velocity,
  output logic [NUM_VOICES-1:0]   voice_trigger,
  output logic [NUM_VOICES-1:0]   voice_release,
  output logic                    dropped
);

  localparam int IW = $clog2(NUM_VOICES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_VOICES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Latched event and scan results
  logic          on_q, on_d;
  logic [6:0]    note_q, note_d;
  logic [6:0]    vel_q, vel_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          match_vld_q, match_vld_d;
  logic [IW-1:0] match_idx_q, match_idx_d;
  logic          free_vld_q, free_vld_d;
  logic [IW-1:0] free_idx_q, free_idx_d;
  logic [IW-1:0] oldest_idx_q, oldest_idx_d;

  // Per-voice state
  logic [NUM_VOICES-1:0] active_q, active_d;
  logic [6:0]            vnote_q [NUM_VOICES];
  logic [6:0]            vnote_d [NUM_VOICES];
  logic [6:0]            vvel_q  [NUM_VOICES];
  logic [6:0]            vvel_d  [NUM_VOICES];
  logic [IW-1:0]         rank_q  [NUM_VOICES];
  logic [IW-1:0]         rank_d  [NUM_VOICES];

  // Output pulses
  logic [NUM_VOICES-1:0] trig_q, trig_d;
  logic [NUM_VOICES-1:0] rel_q, rel_d;
  logic                  drop_q, drop_d;

  // Commit-time decision helpers
  logic          give_on;
  logic [IW-1:0] tgt;

  // Events are only accepted while idle and no panic is in progress
  assign ev_ready = (state_q == IDLE) && !panic;

  // Next-state, scan bookkeeping and commit decisions
  always_comb begin
    state_d      = state_q;
    on_d         = on_q;
    note_d       = note_q;
    vel_d        = vel_q;
    idx_d        = idx_q;
    match_vld_d  = match_vld_q;
    match_idx_d  = match_idx_q;
    free_vld_d   = free_vld_q;
    free_idx_d   = free_idx_q;
    oldest_idx_d = oldest_idx_q;
    active_d     = active_q;
    vnote_d      = vnote_q;
    vvel_d       = vvel_q;
    rank_d       = rank_q;
    trig_d       = '0;
    rel_d        = '0;
    drop_d       = 1'b0;
    give_on      = 1'b0;
    tgt          = '0;

    unique case (state_q)
      IDLE: begin
        if (ev_valid && ev_ready) begin
          // A note-on with zero velocity is a note-off by MIDI convention
          on_d         = ev_on && (ev_velocity != 7'd0);
          note_d       = ev_note;
          vel_d        = ev_velocity;
          idx_d        = '0;
          match_vld_d  = 1'b0;
          match_idx_d  = '0;
          free_vld_d   = 1'b0;
          free_idx_d   = '0;
          oldest_idx_d = '0;
          state_d      = SEARCH;
        end
      end

      SEARCH: begin
        if (active_q[idx_q] && (vnote_q[idx_q] == note_q) && !match_vld_q) begin
          match_vld_d = 1'b1;
          match_idx_d = idx_q;
        end
        if (!active_q[idx_q] && !free_vld_q) begin
          free_vld_d = 1'b1;
          free_idx_d = idx_q;
        end
        if (rank_q[idx_q] == LAST_IDX) begin
          oldest_idx_d = idx_q;
        end
        if (idx_q == LAST_IDX) begin
          state_d = COMMIT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      COMMIT: begin
        state_d = IDLE;
        if (on_q) begin
          if (match_vld_q) begin
            give_on = 1'b1;
            tgt     = match_idx_q;
          end else if (free_vld_q) begin
            give_on = 1'b1;
            tgt     = free_idx_q;
          end else begin
`ifdef VOICE_STEAL_EN
            // Steal the oldest voice: its old note is released and the new one
            // triggered in the same cycle
            give_on            = 1'b1;
            tgt                = oldest_idx_q;
            rel_d[oldest_idx_q] = 1'b1;
`else
            drop_d = 1'b1;
`endif
          end
        end else if (match_vld_q) begin
          active_d[match_idx_q] = 1'b0;
          rel_d[match_idx_q]    = 1'b1;
        end

        if (give_on) begin
          active_d[tgt] = 1'b1;
          vnote_d[tgt]  = note_q;
          vvel_d[tgt]   = vel_q;
          trig_d[tgt]   = 1'b1;
          // Move the target to the front of the age order; only voices that
          // were younger than it shift back, so ranks stay a permutation
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (rank_q[i] < rank_q[tgt]) begin
              rank_d[i] = rank_q[i] + 1'b1;
            end
          end
          rank_d[tgt] = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Panic overrides everything, including a commit in the same cycle;
    // notes, velocities and ranks are kept
    if (panic) begin
      state_d  = IDLE;
      active_d = '0;
      rel_d    = active_q;
      trig_d   = '0;
      drop_d   = 1'b0;
      vnote_d  = vnote_q;
      vvel_d   = vvel_q;
      rank_d   = rank_q;
    end
  end

  // FSM state, voice state and output pulse registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      active_q <= '0;
      trig_q   <= '0;
      rel_q    <= '0;
      drop_q   <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        vnote_q[i] <= '0;
        vvel_q[i]  <= '0;
        rank_q[i]  <= IW'(i);
      end
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      trig_q   <= trig_d;
      rel_q    <= rel_d;
      drop_q   <= drop_d;
      vnote_q  <= vnote_d;
      vvel_q   <= vvel_d;
      rank_q   <= rank_d;
    end
  end

  // Latched event and scan results; only meaningful while an event is in flight
  always_ff @(posedge clk) begin
    on_q         <= on_d;
    note_q       <= note_d;
    vel_q        <= vel_d;
    idx_q        <= idx_d;
    match_vld_q  <= match_vld_d;
    match_idx_q  <= match_idx_d;
    free_vld_q   <= free_vld_d;
    free_idx_q   <= free_idx_d;
    oldest_idx_q <= oldest_idx_d;
  end

  // Pack per-voice registers onto the flat output buses
  always_comb begin
    voice_note     = '0;
    voice_velocity = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      voice_note[7*i +: 7]     = vnote_q[i];
      voice_velocity[7*i +: 7] = vvel_q[i];
    end
  end

  assign voice_active  = active_q;
  assign voice_trigger = trig_q;
  assign voice_release = rel_q;
  assign dropped       = drop_q;

endmodule
